// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler
//   Lets the game-state updaters (falling block, stack, score) own the shared
//   write path only while the VGA scan is in vertical blanking. Update
//   requests are sampled once, at the first blanking line. They are then
//   served one at a time, lowest index first. The block also keeps the frame
//   counter and generates the fall-rate tick for the drop logic.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   y            current VGA line, synchronous to clk
//   req          per-requester "update wanted this frame" level
//   done         per-requester completion pulse
//   pause        freezes fall-rate counting
//   clr_err      clears the sticky error flags
//   grant        one-hot (or zero) write-path ownership
//   busy         high while scanning or granting
//   in_vblank    registered (y >= V_ACTIVE)
//   frame_cnt    frames elapsed, wraps at 2^16
//   fall_tick    one-cycle pulse every FALL_DIV unpaused frames
//   overrun_err  sticky: a grant was cut off by active video
//   timeout_err  sticky: a grant was cut off by the timeout
module vblank_update_scheduler #(
    parameter int V_ACTIVE = 480,
    parameter int NUM_REQ  = 3,
    parameter int FALL_DIV = 30,
    parameter int TIMEOUT  = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         y,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic               pause,
    input  logic               clr_err,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               in_vblank,
    output logic [15:0]        frame_cnt,
    output logic               fall_tick,
    output logic               overrun_err,
    output logic               timeout_err
);
    localparam logic [9:0] VA = 10'(V_ACTIVE);
    localparam int FW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] pending, pending_nxt, grant_nxt, lowbit;
    logic [TW-1:0]      tcnt, tcnt_nxt;
    logic [FW-1:0]      fall_cnt;
    logic [9:0]         y_prev;
    logic               vb_start, vb_end, to_set, ov_set;

    assign vb_start = (y >= VA) && (y_prev < VA);
    assign vb_end   = (y < VA) && (y_prev >= VA);
    assign busy     = (state != IDLE);
    // Isolate the lowest set bit: that is the highest-priority pending requester.
    assign lowbit   = pending & (~pending + NUM_REQ'(1));

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        grant_nxt   = grant;
        tcnt_nxt    = tcnt;
        to_set      = 1'b0;
        ov_set      = 1'b0;
        if (vb_end && state != IDLE) begin
            // Active video is back. Abandon everything left in this frame.
            grant_nxt   = '0;
            pending_nxt = '0;
            state_nxt   = IDLE;
            ov_set      = |grant;
        end else begin
            case (state)
                IDLE: if (vb_start) begin
                    pending_nxt = req;
                    state_nxt   = SCAN;
                end
                SCAN: if (pending == '0) begin
                    state_nxt = IDLE;
                end else begin
                    grant_nxt   = lowbit;
                    pending_nxt = pending & ~lowbit;
                    tcnt_nxt    = '0;
                    state_nxt   = GRANT;
                end
                GRANT: if (|(done & grant)) begin
                    grant_nxt = '0;
                    state_nxt = SCAN;
                end else if (tcnt == TW'(TIMEOUT)) begin
                    grant_nxt = '0;
                    to_set    = 1'b1;
                    state_nxt = SCAN;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            grant   <= '0;
            tcnt    <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            grant   <= grant_nxt;
            tcnt    <= tcnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_prev      <= '0;
            in_vblank   <= 1'b0;
            frame_cnt   <= '0;
            fall_cnt    <= '0;
            fall_tick   <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            y_prev    <= y;
            in_vblank <= (y >= VA);
            fall_tick <= 1'b0;
            if (vb_start) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (!pause) begin
                    if (fall_cnt == FW'(FALL_DIV - 1)) begin
                        fall_cnt  <= '0;
                        fall_tick <= 1'b1;
                    end else begin
                        fall_cnt <= fall_cnt + FW'(1);
                    end
                end
            end
            // A set event in the same cycle as clr_err takes precedence.
            if (ov_set)       overrun_err <= 1'b1;
            else if (clr_err) overrun_err <= 1'b0;
            if (to_set)       timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vblank_update_scheduler.sv
module tb_vblank_update_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  y = '0;
    logic [2:0]  req = '0;
    logic [2:0]  done = '0;
    logic        pause = 1'b0;
    logic        clr_err = 1'b0;
    logic [2:0]  grant;
    logic        busy, in_vblank, fall_tick, overrun_err, timeout_err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    vblank_update_scheduler #(
        .V_ACTIVE(480), .NUM_REQ(3), .FALL_DIV(3), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .y(y), .req(req), .done(done), .pause(pause),
        .clr_err(clr_err), .grant(grant), .busy(busy), .in_vblank(in_vblank),
        .frame_cnt(frame_cnt), .fall_tick(fall_tick),
        .overrun_err(overrun_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cross 479 -> 480. On return the vb_start edge has just happened.
    task automatic vb_enter();
        y = 10'd479;
        step();
        y = 10'd480;
        step();
    endtask

    task automatic fall_frame(input logic exp_tick);
        y = 10'd479;
        step();
        chk("fall_pre", fall_tick, 0);
        y = 10'd480;
        step();
        chk("fall_tick", fall_tick, exp_tick);
        step();
        chk("fall_width", fall_tick, 0);
        y = 10'd0;
        step();
    endtask

    initial begin
        int busy_cycles;
        logic [2:0] g;

        // Reset and an idle frame
        step(); step(); step();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_vblank", in_vblank, 0);
        chk("rst_errs", {overrun_err, timeout_err, fall_tick}, 0);
        rst = 1'b0;
        busy_cycles = 0;
        for (int yy = 0; yy <= 524; yy++) begin
            y = 10'(yy);
            step();
            chk("idle_grant", grant, 0);
            if (busy) busy_cycles++;
            if (yy == 480) chk("idle_vblank", in_vblank, 1);
        end
        chk("idle_busy_len", busy_cycles, 1);
        chk("idle_frame", frame_cnt, 1);
        y = 10'd0;
        step();
        chk("idle_vblank_off", in_vblank, 0);

        // Priority order: 001, 010, 100, each 6 cycles wide, 1-cycle gaps
        req = 3'b111;
        vb_enter();
        chk("pri_scan_busy", busy, 1);
        chk("pri_scan_grant", grant, 0);
        for (int i = 0; i < 3; i++) begin
            g = 3'b001 << i;
            step();
            chk("pri_on", grant, g);
            for (int k = 1; k <= 5; k++) begin
                if (i == 0 && k == 2) done = 3'b110;
                step();
                done = 3'b000;
                chk("pri_hold", grant, g);
            end
            done = g;
            step();
            done = 3'b000;
            chk("pri_gap", grant, 0);
            chk("pri_gap_busy", busy, 1);
        end
        step();
        chk("pri_end_busy", busy, 0);
        chk("pri_end_grant", grant, 0);
        req = 3'b000;
        y = 10'd0;
        step();
        chk("pri_no_err", {overrun_err, timeout_err}, 0);

        // Late request is ignored until the next vblank edge
        vb_enter();
        req = 3'b010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("late_grant", grant, 0);
        end
        chk("late_busy", busy, 0);
        y = 10'd0;
        step();
        vb_enter();
        step();
        chk("late_next", grant, 3'b010);
        done = 3'b010;
        step();
        done = 3'b000;
        chk("late_done", grant, 0);
        step();
        chk("late_idle", busy, 0);
        y = 10'd0;
        step();

        // Timeout (TIMEOUT=15 -> 16 cycles), then requester 1, then overrun
        req = 3'b011;
        vb_enter();
        step();
        chk("to_on", grant, 3'b001);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("to_hold", grant, 3'b001);
        end
        chk("to_err_early", timeout_err, 0);
        step();
        chk("to_drop", grant, 0);
        chk("to_err", timeout_err, 1);
        step();
        chk("to_next", grant, 3'b010);
        step(); step();
        chk("ov_hold", grant, 3'b010);
        y = 10'd0;
        step();
        chk("ov_drop", grant, 0);
        chk("ov_err", overrun_err, 1);
        chk("ov_busy", busy, 0);
        chk("ov_to_sticky", timeout_err, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_errs", {overrun_err, timeout_err}, 0);

        // Async reset mid-grant
        req = 3'b010;
        vb_enter();
        step();
        chk("ar_grant", grant, 3'b010);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_grant_drop", grant, 0);
        chk("ar_frame", frame_cnt, 0);
        chk("ar_busy", busy, 0);
        y = 10'd0;
        step(); step();
        rst = 1'b0;
        step();
        chk("ar_idle", grant, 0);
        vb_enter();
        chk("ar_frame1", frame_cnt, 1);
        step();
        chk("ar_regrant", grant, 3'b010);
        done = 3'b010;
        step();
        done = 3'b000;
        req = 3'b000;
        y = 10'd0;
        step();

        // Fall tick from a cold reset: ticks on 3,6,9; paused 10..12; next on 15
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int f = 1; f <= 15; f++) begin
            pause = (f >= 10 && f <= 12);
            fall_frame(f == 3 || f == 6 || f == 9 || f == 15);
        end
        pause = 1'b0;
        chk("fall_frames", frame_cnt, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
